// File: rtl/am_pkg.sv
// Shared opcode values and FSM state encoding for the addressing-mode engine.
// No logic lives here; everything is imported by addr_mode_engine.
// The STA opcode is always defined; whether it decodes is decided by AM_STA_EN.
package am_pkg;

  // Operation codes
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_MVI = 4'b1100;
  localparam logic [3:0] OP_LDA = 4'b1101;
  localparam logic [3:0] OP_STA = 4'b1110;

  // Engine states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IMM  = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/addr_mode_engine.sv
// Purpose: decode MOV/MVI/LDA (and STA when AM_STA_EN is defined) into register writebacks and memory/immediate requests.
// Latency: MOV writes back 1 cycle after accept; MVI/LDA take 1 + wait cycles + 1; illegal opcodes pulse err 1 cycle after accept.
// Backpressure: in_ready is high only in IDLE; imm_req/mem_req are held until imm_valid/mem_ack, with no timeout.
module addr_mode_engine
  import am_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RA_W     = 3,
  parameter int ACC_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [RA_W-1:0]   op1_regaddr,
  input  logic [DATA_W-1:0] op1_data,
  input  logic [DATA_W-1:0] op2_data,
  input  logic [DATA_W-1:0] acc_data,
  output logic              imm_req,
  input  logic              imm_valid,
  input  logic [DATA_W-1:0] imm_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_regaddr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  state_t            state;
  // Destination register captured at accept; MVI needs it after op1_regaddr may have changed.
  logic [RA_W-1:0]   rd_q;

`ifdef AM_STA_EN
  // Distinguishes a store from a load while waiting in MEM.
  logic              store_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
`else
  // Without stores the write side of the memory port is constant.
  logic unused_acc;

  assign mem_we     = 1'b0;
  assign mem_wdata  = '0;
  assign unused_acc = ^acc_data;
`endif

  // Single FSM: every output is a register updated on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      imm_req    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      wb_valid   <= 1'b0;
      wb_regaddr <= '0;
      wb_data    <= '0;
      err        <= 1'b0;
      rd_q       <= '0;
`ifdef AM_STA_EN
      store_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      wb_valid <= 1'b0;
      err      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            rd_q     <= op1_regaddr;
            case (opcode)
              OP_MOV: begin
                // Source data is already on hand, so write back immediately.
                state      <= ST_WB;
                wb_valid   <= 1'b1;
                wb_regaddr <= op1_regaddr;
                wb_data    <= op2_data;
              end
              OP_MVI: begin
                state   <= ST_IMM;
                imm_req <= 1'b1;
              end
              OP_LDA: begin
                state    <= ST_MEM;
                mem_req  <= 1'b1;
                mem_addr <= op1_data;
`ifdef AM_STA_EN
                store_q  <= 1'b0;
                mem_we_q <= 1'b0;
`endif
              end
`ifdef AM_STA_EN
              OP_STA: begin
                state       <= ST_MEM;
                mem_req     <= 1'b1;
                mem_addr    <= op1_data;
                store_q     <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= acc_data;
              end
`endif
              default: begin
                state <= ST_ERR;
                err   <= 1'b1;
              end
            endcase
          end
        end

        ST_IMM: begin
          // Keep requesting until the immediate word shows up.
          if (imm_valid) begin
            state      <= ST_WB;
            imm_req    <= 1'b0;
            wb_valid   <= 1'b1;
            wb_regaddr <= rd_q;
            wb_data    <= imm_data;
          end
        end

        ST_MEM: begin
          // Request fields stay frozen until the ack.
          if (mem_ack) begin
            mem_req <= 1'b0;
`ifdef AM_STA_EN
            if (store_q) begin
              // Stores have no register result; go straight back to IDLE.
              state    <= ST_IDLE;
              in_ready <= 1'b1;
              mem_we_q <= 1'b0;
            end else begin
              state      <= ST_WB;
              wb_valid   <= 1'b1;
              wb_regaddr <= RA_W'(ACC_ADDR);
              wb_data    <= mem_rdata;
            end
`else
            state      <= ST_WB;
            wb_valid   <= 1'b1;
            wb_regaddr <= RA_W'(ACC_ADDR);
            wb_data    <= mem_rdata;
`endif
          end
        end

        ST_WB: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end

        ST_ERR: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          imm_req  <= 1'b0;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
